// File: rtl/bcd_subtractor_seq.sv
// Sequential packed-BCD subtractor: one digit per cycle, LSD first, with a second
// ten's-complement pass that turns a negative first-pass result into sign/magnitude.
module bcd_subtractor_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  input  logic                bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*DIGITS-1:0] diff_o,
  output logic                neg_o,
  output logic                bout_o,
  output logic                invalid_o
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StSub, StNegate, StFin} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    w_q, w_d;
  logic            borrow_q, borrow_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            neg_q, neg_d;
  logic            bout_q, bout_d;
  logic            invalid_q, invalid_d;

  logic [3:0]      op_a, op_b;
  logic [4:0]      raw;
  logic            step_borrow;
  logic [3:0]      step_digit;
  logic [W-1:0]    w_shift;
  logic            accept;
  logic            capture_bad;
  logic            last_digit;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign accept      = start_i && ((state_q == StIdle) || (state_q == StFin));
  assign capture_bad = has_bad_digit(a_i) || has_bad_digit(b_i);
  assign last_digit  = (idx_q == LastIdx);

  // Shared digit step: SUB uses a-b, NEGATE uses 0-w; the result digit enters w from the top.
  always_comb begin
    op_a = 4'd0;
    op_b = w_q[3:0];
    if (state_q == StSub) begin
      op_a = a_q[3:0];
      op_b = b_q[3:0];
    end
    raw         = {1'b0, op_a} - {1'b0, op_b} - {4'b0000, borrow_q};
    step_borrow = raw[4];
    step_digit  = raw[4] ? (raw[3:0] + 4'd10) : raw[3:0];
    w_shift     = (w_q >> 4) | (W'(step_digit) << (W - 4));
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = capture_bad ? StFin : StSub;
      end
      StSub: begin
        if (last_digit) state_d = step_borrow ? StNegate : StFin;
      end
      StNegate: begin
        if (last_digit) state_d = StFin;
      end
      StFin: begin
        if (start_i) state_d = capture_bad ? StFin : StSub;
        else         state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    w_d       = w_q;
    borrow_d  = borrow_q;
    idx_d     = idx_q;
    diff_d    = diff_q;
    neg_d     = neg_q;
    bout_d    = bout_q;
    invalid_d = invalid_q;
    if (accept) begin
      a_d      = a_i;
      b_d      = b_i;
      w_d      = '0;
      borrow_d = bin_i;
      idx_d    = '0;
      if (capture_bad) begin
        diff_d    = '0;
        neg_d     = 1'b0;
        bout_d    = 1'b0;
        invalid_d = 1'b1;
      end
    end else if (state_q == StSub) begin
      a_d      = a_q >> 4;
      b_d      = b_q >> 4;
      w_d      = w_shift;
      borrow_d = step_borrow;
      idx_d    = idx_q + 1'b1;
      if (last_digit) begin
        idx_d    = '0;
        borrow_d = 1'b0;
        if (!step_borrow) begin
          diff_d    = w_shift;
          neg_d     = 1'b0;
          bout_d    = 1'b0;
          invalid_d = 1'b0;
        end
      end
    end else if (state_q == StNegate) begin
      w_d      = w_shift;
      borrow_d = step_borrow;
      idx_d    = idx_q + 1'b1;
      if (last_digit) begin
        idx_d     = '0;
        diff_d    = w_shift;
        neg_d     = 1'b1;
        bout_d    = 1'b1;
        invalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q       <= '0;
      b_q       <= '0;
      w_q       <= '0;
      borrow_q  <= 1'b0;
      idx_q     <= '0;
      diff_q    <= '0;
      neg_q     <= 1'b0;
      bout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      w_q       <= w_d;
      borrow_q  <= borrow_d;
      idx_q     <= idx_d;
      diff_q    <= diff_d;
      neg_q     <= neg_d;
      bout_q    <= bout_d;
      invalid_q <= invalid_d;
    end
  end

  // Output logic
  always_comb begin
    busy_o    = (state_q == StSub) || (state_q == StNegate);
    done_o    = (state_q == StFin);
    diff_o    = diff_q;
    neg_o     = neg_q;
    bout_o    = bout_q;
    invalid_o = invalid_q;
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Directed and randomized checks of bcd_subtractor_seq against an integer-arithmetic model.
module tb_bcd_subtractor_seq;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, neg, bout, invalid;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  bcd_subtractor_seq #(.DIGITS(D)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .bin_i    (bin),
    .busy_o   (busy),
    .done_o   (done),
    .diff_o   (diff),
    .neg_o    (neg),
    .bout_o   (bout),
    .invalid_o(invalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_val(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int m);
    logic [W-1:0] r = '0;
    int x = m;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic bad_bcd(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       output logic [W-1:0] ed, output logic en, output logic eb,
                       output logic ei, output int elat, output int ebusy);
    int r;
    if (bad_bcd(av) || bad_bcd(bv)) begin
      ed = '0; en = 1'b0; eb = 1'b0; ei = 1'b1; elat = 1; ebusy = 0;
    end else begin
      r  = bcd_val(av) - bcd_val(bv) - int'(bi);
      en = (r < 0);
      eb = en;
      ei = 1'b0;
      ed = to_bcd(en ? -r : r);
      elat  = en ? 2 * D + 1 : D + 1;
      ebusy = en ? 2 * D : D;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Call at a falling edge; returns at a falling edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input bit glitch, input string tag);
    logic [W-1:0] ed;
    logic         en, eb, ei;
    int           elat, ebusy, lat, busy_n;
    bit           seen;
    model(av, bv, bi, ed, en, eb, ei, elat, ebusy);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk);
    lat = 0; busy_n = 0; seen = 0;
    while (!seen && lat < 4 * D + 4) begin
      @(negedge clk);
      lat++;
      if (glitch && lat == 2) begin
        start = 1'b1; a = ~av; b = '0; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(ebusy));
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " neg"}, 32'(neg), 32'(en));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    chk({tag, " invalid"}, 32'(invalid), 32'(ei));
    @(negedge clk);
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] ed, na, nb;
    logic         en, eb, ei, nbin;
    int           elat, ebusy, lat, snap;
    bit           seen;

    rst_ni = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset flags", {29'd0, neg, bout, invalid}, 32'd0);

    // START on the very first edge after reset release
    rst_ni = 1'b1;
    run_op(16'h0523, 16'h0178, 1'b0, 1'b0, "pos_0523");
    run_op(16'h0100, 16'h0250, 1'b0, 1'b0, "neg_0100");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "zero_bin");
    run_op(16'h9999, 16'h9999, 1'b0, 1'b0, "equal_9999");
    run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, "invalid_a");
    run_op(16'h0523, 16'h0178, 1'b0, 1'b0, "clear_inv");
    run_op(16'h1234, 16'h00F0, 1'b1, 1'b0, "invalid_b");
    run_op(16'h0000, 16'h9999, 1'b1, 1'b0, "max_neg");
    run_op(16'h4821, 16'h1357, 1'b1, 1'b1, "start_mid_sub");
    run_op(16'h0100, 16'h0250, 1'b0, 1'b1, "start_mid_neg");

    // Reset asserted during NEGATE aborts the operation
    a = 16'h0100; b = 16'h0250; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (D + 1) @(negedge clk);
    chk("pre_abort busy", 32'(busy), 32'd1);
    snap = done_cnt;
    rst_ni = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort diff", 32'(diff), 32'd0);
    chk("abort flags", {29'd0, neg, bout, invalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2 * D + 3) @(negedge clk);
    chk("abort no_done", 32'(done_cnt - snap), 32'd0);
    chk("abort idle diff", 32'(diff), 32'd0);

    // Back-to-back stream with START held high
    snap = done_cnt;
    a = rand_bcd(); b = rand_bcd(); bin = 1'($urandom_range(0, 1));
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      model(a, b, bin, ed, en, eb, ei, elat, ebusy);
      lat = 0; seen = 0;
      while (!seen && lat < 4 * D + 4) begin
        @(negedge clk);
        lat++;
        if (done === 1'b1) seen = 1;
      end
      chk("stream latency", 32'(lat), 32'(elat));
      chk("stream diff", 32'(diff), 32'(ed));
      chk("stream flags", {29'd0, neg, bout, invalid}, {29'd0, en, eb, ei});
      if (k < 29) begin
        na = rand_bcd(); nb = rand_bcd(); nbin = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) na[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
        a = na; b = nb; bin = nbin;
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    chk("stream done_count", 32'(done_cnt - snap), 32'd30);
    chk("stream idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
